cam_frame_capture: RTL and testbench

//  Camera-side capture stage feeding the camera-input FIFO ahead of the PSRAM video controller.

---
 rtl/cam_frame_capture.sv | 171 +++++++++++++++++
 tb/tb_cam_frame_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_capture.sv
// OV7670 RGB565 capture: byte-pair assembly, crop to the LCD window, {sof, pixel} FIFO writes.
// Optional statistics outputs are enabled by defining CAM_CAPTURE_STATS_EN.
module cam_frame_capture #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int CROP_X0    = 80,
  parameter int CROP_Y0    = 104,
  parameter int OUT_WIDTH  = 480,
  parameter int OUT_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calib_done,
  input  logic        cam_vsync,
  input  logic        href,
  input  logic [7:0]  p_data,
  input  logic        fifo_full,
  output logic [16:0] fifo_data,
  output logic        fifo_wr_en,
  output logic        frame_active,
  output logic        overflow
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic [18:0] last_pix
`endif
);

  localparam logic [9:0] X_LO    = 10'(CROP_X0);
  localparam logic [9:0] X_HI    = 10'(CROP_X0 + OUT_WIDTH);
  localparam logic [9:0] Y_LO    = 10'(CROP_Y0);
  localparam logic [9:0] Y_HI    = 10'(CROP_Y0 + OUT_HEIGHT);
  localparam logic [9:0] COL_MAX = 10'(SRC_WIDTH);
  localparam logic [9:0] ROW_MAX = 10'(SRC_HEIGHT);

  typedef enum logic [2:0] {
    S_WAIT_CALIB,
    S_WAIT_BLANK,
    S_ARMED,
    S_CAPTURE,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [15:0] r_pix;
  logic        r_pend;
  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic        r_href_d;
  logic        r_overflow;

  logic w_sof_wr;
  logic w_pix_wr;
  logic w_overrun;
  logic w_pix_done;
  logic w_in_win;
  logic w_href_fall;

  // Writes are qualified by fifo_full in the cycle they are presented, so the
  // strobe can never fire into a full FIFO.
  assign w_sof_wr    = (r_state == S_ARMED) && !cam_vsync && !fifo_full;
  assign w_pix_wr    = r_pend && (r_state == S_CAPTURE) && !fifo_full;
  assign w_overrun   = r_pend && (r_state == S_CAPTURE) && fifo_full;
  assign w_pix_done  = (r_state == S_CAPTURE) && href && r_phase;
  assign w_href_fall = r_href_d && !href;
  assign w_in_win    = (r_col >= X_LO) && (r_col < X_HI) &&
                       (r_row >= Y_LO) && (r_row < Y_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_CALIB;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values; blocking here would create order-dependent races.
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_WAIT_CALIB: if (calib_done) w_next = S_WAIT_BLANK;
      S_WAIT_BLANK: if (cam_vsync)  w_next = S_ARMED;
      S_ARMED: begin
        // A full FIFO at frame start skips the frame; re-arming needs a new blank.
        if (!cam_vsync) w_next = fifo_full ? S_WAIT_BLANK : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_overrun)      w_next = S_DROP;
        else if (cam_vsync) w_next = S_WAIT_BLANK;
      end
      S_DROP:       if (cam_vsync)  w_next = S_WAIT_BLANK;
      default:      w_next = S_WAIT_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_pix      <= '0;
      r_pend     <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_href_d   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_href_d <= href;
      r_phase  <= (r_state == S_CAPTURE) && href && !r_phase;
      if ((r_state == S_CAPTURE) && href && !r_phase) r_hi <= p_data;

      r_pend <= w_pix_done && w_in_win;
      if (w_pix_done && w_in_win) r_pix <= {r_hi, p_data};

      // Counters park just outside the source size so they can never wrap back into the window.
      if (w_sof_wr || w_href_fall)           r_col <= '0;
      else if (w_pix_done && r_col != COL_MAX) r_col <= r_col + 10'd1;

      if (w_sof_wr)                          r_row <= '0;
      else if (w_href_fall && r_row != ROW_MAX) r_row <= r_row + 10'd1;

      if (w_sof_wr)       r_overflow <= 1'b0;
      else if (w_overrun) r_overflow <= 1'b1;
    end
  end

  assign fifo_wr_en   = w_sof_wr || w_pix_wr;
  assign fifo_data    = w_sof_wr ? 17'h10000 : {1'b0, r_pix};
  assign frame_active = (r_state == S_CAPTURE);
  assign overflow     = r_overflow;

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_drop_count;
  logic [18:0] r_last_pix;
  logic [18:0] r_pix_cnt;
  logic        w_frame_end;

  assign w_frame_end = ((r_state == S_CAPTURE) || (r_state == S_DROP)) &&
                       (w_next == S_WAIT_BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_last_pix    <= '0;
      r_pix_cnt     <= '0;
    end else begin
      if (w_sof_wr)      r_pix_cnt <= '0;
      else if (w_pix_wr) r_pix_cnt <= r_pix_cnt + 19'd1;

      if (w_frame_end) begin
        // A pixel written in the closing cycle still belongs to this frame.
        r_last_pix <= r_pix_cnt + {18'd0, w_pix_wr};
        if (r_state == S_CAPTURE)        r_frame_count <= r_frame_count + 16'd1;
        else if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
  assign last_pix    = r_last_pix;
`endif

endmodule

// File: tb/tb_cam_frame_capture.sv
// Self-checking bench for cam_frame_capture with a small 8x6 source cropped to 4x3 at (2,1).
// Expected FIFO words come from a frame-level model of the crop/marker/overrun rules.
module tb_cam_frame_capture;

  localparam int SW = 8, SH = 6, X0 = 2, Y0 = 1, OW = 4, OH = 3;

  logic        clk = 1'b0;
  logic        rst_n, calib_done, cam_vsync, href, fifo_full;
  logic [7:0]  p_data;
  logic [16:0] fifo_data;
  logic        fifo_wr_en, frame_active, overflow;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_count, drop_count;
  logic [18:0] last_pix;
`endif

  cam_frame_capture #(
    .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .CROP_X0(X0), .CROP_Y0(Y0),
    .OUT_WIDTH(OW), .OUT_HEIGHT(OH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .cam_vsync(cam_vsync),
    .href(href), .p_data(p_data), .fifo_full(fifo_full), .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en), .frame_active(frame_active), .overflow(overflow)
`ifdef CAM_CAPTURE_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count), .last_pix(last_pix)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      got_q.push_back(fifo_data);
      check("wr_while_full", {31'd0, fifo_full}, 32'd0);
    end
  end

  // Frame model state
  bit          pend_v, dropped, live, ov_exp, m_cal;
  logic [15:0] pend_w;
  int          kept, pix_this;
  int          e_frames, e_drops, e_last;

  // Per-frame scenario knobs (-1 = unused)
  int g_lens[6];
  int g_full_at, g_cut_line, g_cut_b, g_rst_line, g_rst_b, g_cal_line;
  bit g_sof_full;

  task automatic set_defaults();
    foreach (g_lens[i]) g_lens[i] = 2 * SW;
    g_full_at = -1; g_cut_line = -1; g_cut_b = -1;
    g_rst_line = -1; g_rst_b = -1; g_cal_line = -1; g_sof_full = 0;
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] d, input logic f);
    cam_vsync = v; href = h; p_data = d; fifo_full = f;
    @(posedge clk);
    #1;
  endtask

  // Resolves the pixel completed last cycle: it is written now unless this is the overrun point.
  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    logic f;
    f = 1'b0;
    if (pend_v) begin
      pend_v = 0;
      kept++;
      if (kept == g_full_at) begin
        f = 1'b1; dropped = 1; ov_exp = 1;
      end else begin
        exp_q.push_back({1'b0, pend_w});
        pix_this++;
      end
    end
    cyc(v, h, d, f);
  endtask

  task automatic frame_end();
    if (dropped) begin
      if (e_drops != 16'hFFFF) e_drops++;
    end else begin
      e_frames = (e_frames + 1) % 65536;
    end
    e_last = pix_this;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_en",  {31'd0, fifo_wr_en},   32'd0);
    check("rst_data",   {15'd0, fifo_data},    32'd0);
    check("rst_active", {31'd0, frame_active}, 32'd0);
    check("rst_ovf",    {31'd0, overflow},     32'd0);
    #1 rst_n = 1'b1;
    e_frames = 0; e_drops = 0; e_last = 0; ov_exp = 0;
  endtask

  task automatic run_frame(input string name);
    bit         vs, end_now;
    logic [7:0] d, hi;
    hi = '0;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    live = m_cal && !g_sof_full;
    if (live) begin
      exp_q.push_back(17'h10000);
      ov_exp = 0;
    end
    kept = 0; dropped = 0; pix_this = 0; pend_v = 0; vs = 0;
    cyc(1'b0, 1'b0, 8'h00, g_sof_full);
    tick(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 6; r++) begin
      if (r == g_cal_line) begin
        calib_done = 1'b1; m_cal = 1;
      end
      for (int b = 0; b < g_lens[r]; b++) begin
        d = 8'($urandom);
        end_now = 0;
        if (r == g_rst_line && b == g_rst_b) begin
          reset_pulse();
          pend_v = 0; live = 0;
        end
        if (r == g_cut_line && b == g_cut_b) begin
          vs = 1; end_now = live;
        end
        tick(vs, 1'b1, d);
        if (end_now) frame_end();
        if (end_now) live = 0;
        if (b % 2 == 0) begin
          hi = d;
        end else if (live && !dropped && (b / 2) >= X0 && (b / 2) < X0 + OW &&
                     r >= Y0 && r < Y0 + OH) begin
          pend_v = 1; pend_w = {hi, d};
        end
      end
      tick(vs, 1'b0, 8'h00);
      tick(vs, 1'b0, 8'h00);
    end
    if (live) frame_end();
    check({name, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s_w%0d", name, i),
            (i < got_q.size()) ? {15'd0, got_q[i]} : 32'hFFFF_FFFF, {15'd0, exp_q[i]});
    check({name, "_ovf"},    {31'd0, overflow},     {31'd0, ov_exp});
    check({name, "_active"}, {31'd0, frame_active}, {31'd0, live && !dropped && !vs});
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; calib_done = 1'b0; cam_vsync = 1'b0; href = 1'b0;
    p_data = '0; fifo_full = 1'b0;
    m_cal = 0; ov_exp = 0; pend_v = 0; e_frames = 0; e_drops = 0; e_last = 0;
    @(posedge clk);
    #1;
    check("reset_wr_en",  {31'd0, fifo_wr_en},   32'd0);
    check("reset_data",   {15'd0, fifo_data},    32'd0);
    check("reset_active", {31'd0, frame_active}, 32'd0);
    check("reset_ovf",    {31'd0, overflow},     32'd0);
    rst_n = 1'b1;

    set_defaults();                      run_frame("no_calib");
    set_defaults(); g_cal_line = 2;      run_frame("calib_mid");
    set_defaults();                      run_frame("clean");
    set_defaults(); g_lens[1] = 7;       run_frame("odd_line");
    set_defaults(); g_full_at = 3;       run_frame("overrun");
    set_defaults();                      run_frame("after_ovr");
    set_defaults(); g_cut_line = 2; g_cut_b = 8; run_frame("vsync_cut");
    set_defaults();                      run_frame("after_cut");
    set_defaults(); g_sof_full = 1;      run_frame("sof_full");
    set_defaults();                      run_frame("after_skip");
    set_defaults(); g_rst_line = 2; g_rst_b = 8; run_frame("mid_reset");
    set_defaults();                      run_frame("post_reset");

    for (int k = 0; k < 3; k++) begin
      set_defaults();
      foreach (g_lens[i]) g_lens[i] = 9 + int'($urandom_range(7));
      if (k == 0) g_full_at = 2;
      run_frame($sformatf("rand%0d", k));
    end

    repeat (3) tick(1'b1, 1'b0, 8'h00);
`ifdef CAM_CAPTURE_STATS_EN
    check("frame_count", {16'd0, frame_count}, 32'(e_frames));
    check("drop_count",  {16'd0, drop_count},  32'(e_drops));
    check("last_pix",    {13'd0, last_pix},    32'(e_last));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
